mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates one shared single-port memory (fixed read latency) between the IF-stage
//  instruction port (read-only) and the MEM-stage data port (read/write).
//  Sits between the pipeline fetch/memory stages and a unified imem/dmem array.
//  Sequences each access (issue, wait, respond) and returns data to the owning port.
// PARAMETERS
//  ADDR_W   32  address width, all ports
//  DATA_W   32  data width, all ports
//  MEM_LAT  2   cycles from the m_req cycle to valid m_rdata; legal range is >= 1
// PORTS
//  clk      in   1       system clock, rising edge
//  reset    in   1       asynchronous, active-low reset
//  i_req    in   1       instruction read request; held with i_addr until i_gnt
//  i_addr   in   ADDR_W  instruction address
//  i_gnt    out  1       1-cycle pulse: instruction request accepted
//  i_rvalid out  1       1-cycle pulse: i_rdata valid
//  i_rdata  out  DATA_W  instruction read data; 0 when i_rvalid=0
//  d_req    in   1       data request; held with d_we, d_addr, d_wdata until d_gnt
//  d_we     in   1       1 = write, 0 = read
//  d_addr   in   ADDR_W  data address
//  d_wdata  in   DATA_W  data write value
//  d_gnt    out  1       1-cycle pulse: data request accepted
//  d_rvalid out  1       1-cycle pulse: read data valid, or write complete
//  d_rdata  out  DATA_W  data read value; 0 for writes and when d_rvalid=0
//  m_req    out  1       memory access strobe, 1 cycle per access
//  m_we     out  1       memory write enable, qualified by m_req
//  m_addr   out  ADDR_W  memory address (registered, holds last value)
//  m_wdata  out  DATA_W  memory write data (registered, holds last value)
//  m_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after m_req
//  busy     out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset=0): state goes to IDLE immediately. All outputs and registers are 0.
//    Any in-flight access is discarded; no rvalid is issued for it.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    If MEM_LAT=1, ISSUE goes directly to RESP and WAIT is skipped.
//  - IDLE: requests are sampled only in this state. On a clock edge with any request pending:
//    * capture the winner's owner, address, we and wdata;
//    * go to ISSUE.
//  - Arbitration priority: d port beats i port (the older instruction wins).
//  - ISSUE (1 cycle):
//    * m_req=1; m_we, m_addr and m_wdata are driven from the captured values;
//    * the winner's gnt=1 in the same cycle;
//    * load the wait counter with MEM_LAT-1.
//  - WAIT: decrement the counter each cycle; go to RESP when the count reaches 1.
//    WAIT therefore lasts MEM_LAT-1 cycles.
//  - RESP (1 cycle):
//    * the owner's rvalid=1;
//    * on a read, the owner's rdata = m_rdata (combinational pass-through);
//    * on a write, rdata = 0.
//    Go to IDLE on the next edge.
//  - Latency: request first seen in IDLE in cycle N; gnt in cycle N+1; rvalid in cycle N+1+MEM_LAT.
//    Throughput is one access per MEM_LAT+2 cycles.
//  - A request sampled in IDLE is always served, even if req drops before gnt.
//    Dropping req before gnt is a protocol violation.
//  - The requester's address, we and wdata are captured at the IDLE edge. Changes after that edge are ignored.
//  - The i and d gnt/rvalid signals are never high in the same cycle.
//  - Address is passed through unmodified; no alignment check.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    * when both requests are pending in IDLE, the winner is the port not granted last;
//    * a single pending requester always wins;
//    * the last-granted register resets to the i port, so d wins the first conflict.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, d always wins.
// TESTING
//  1 Assert reset mid-sim -> all outputs 0 and busy=0 the same cycle.
//    After release, no stray gnt or rvalid.
//  2 MEM_LAT=2; i read of 0x10 at cycle N; model returns 0xDEADBEEF ->
//    i_gnt, m_req=1, m_addr=0x10, m_we=0 at N+1; i_rvalid=1 with i_rdata=0xDEADBEEF at N+3; busy N+1..N+3.
//  3 i_req and d_req (read 0x20) both at cycle N, fixed priority ->
//    d_gnt at N+1, d_rvalid at N+3; i_gnt at N+5, i_rvalid at N+7.
//  4 d write 0x100 <- 0x12345678 ->
//    m_we=1, m_wdata=0x12345678 in the ISSUE cycle; d_rvalid=1 with d_rdata=0.
//    A following d read of 0x100 returns 0x12345678.
//  5 Reset asserted during WAIT -> m_req=0 and busy=0 immediately.
//    No d_rvalid or i_rvalid ever appears for the aborted access.
//  6 MEM_LAT=1, i read at cycle N -> rvalid at N+2.
//    With ARB_ROUND_ROBIN_EN and two back-to-back conflicts: grants go d, then i.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between an instruction read port
// and a data read/write port. Define ARB_ROUND_ROBIN_EN to alternate winners on conflicts.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               own_d;
  logic               cap_we;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  logic               pick_d;
  logic               take;

  assign take = (state == IDLE) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
  // last_d = 1 when the data port owned the most recent access
  logic last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (take) begin
      last_d <= pick_d;
    end
  end

  assign pick_d = d_req && (!i_req || !last_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      own_d     <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        own_d    <= pick_d;
        cap_we   <= pick_d && d_we;
        cap_addr <= pick_d ? d_addr : i_addr;
        if (pick_d) begin
          cap_wdata <= d_wdata;
        end
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(MEM_LAT - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_req || d_req) state_nxt = ISSUE;
      ISSUE: state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:  if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset clears them in the same cycle
  always_comb begin
    m_req    = (state == ISSUE);
    m_we     = (state == ISSUE) && cap_we;
    m_addr   = cap_addr;
    m_wdata  = cap_wdata;
    i_gnt    = (state == ISSUE) && !own_d;
    d_gnt    = (state == ISSUE) && own_d;
    i_rvalid = (state == RESP) && !own_d;
    d_rvalid = (state == RESP) && own_d;
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = (d_rvalid && !cap_we) ? m_rdata : '0;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table on a MEM_LAT=2 instance,
// plus hand-written sequences for MEM_LAT=1 latency and back-to-back conflicts.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mem_clr;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, m_req2, m_we2, busy2;
  logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;
  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_req1, m_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u2 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_req(m_req2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2),
    .busy(busy2)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .busy(busy1)
  );

  // Unwritten words read back as DEADBEEF + (addr - 0x10)
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hDEADBEEF + (a - 32'h10);
  endfunction

  logic [31:0] wmem2 [256];
  logic        wv2   [256];
  logic [31:0] rd2_p0, rd2_p1;
  logic [31:0] wmem1 [256];
  logic        wv1   [256];
  logic [31:0] rd1_p0;

  assign m_rdata2 = rd2_p1;
  assign m_rdata1 = rd1_p0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) wv2[k] <= 1'b0;
    end else if (m_req2 && m_we2) begin
      wmem2[m_addr2[9:2]] <= m_wdata2;
      wv2[m_addr2[9:2]]   <= 1'b1;
    end
    rd2_p0 <= wv2[m_addr2[9:2]] ? wmem2[m_addr2[9:2]] : dflt(m_addr2);
    rd2_p1 <= rd2_p0;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) wv1[k] <= 1'b0;
    end else if (m_req1 && m_we1) begin
      wmem1[m_addr1[9:2]] <= m_wdata1;
      wv1[m_addr1[9:2]]   <= 1'b1;
    end
    rd1_p0 <= wv1[m_addr1[9:2]] ? wmem1[m_addr1[9:2]] : dflt(m_addr1);
  end

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic        eig, eiv;
    logic [31:0] eird;
    logic        edg, edv;
    logic [31:0] edrd;
    logic        emq, emw;
    logic [31:0] ema, emwd;
    logic        ebusy;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, ir, input logic [31:0] ia, input logic dr, dwe,
                     input logic [31:0] da, dwd, input logic eig, eiv, input logic [31:0] eird,
                     input logic edg, edv, input logic [31:0] edrd, input logic emq, emw,
                     input logic [31:0] ema, emwd, input logic ebusy);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.eig = eig; v.eiv = eiv; v.eird = eird; v.edg = edg; v.edv = edv; v.edrd = edrd;
    v.emq = emq; v.emw = emw; v.ema = ema; v.emwd = emwd; v.ebusy = ebusy;
    vt.push_back(v);
  endtask

  task automatic drive(input logic rst, ir, input logic [31:0] ia, input logic dr, dwe,
                       input logic [31:0] da, dwd);
    @(posedge clk);
    #1;
    reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [134:0] act_v, exp_v;
  logic         seen;
  int           lat;
  logic [31:0]  loser_addr;

  initial begin
    reset = 1'b0; mem_clr = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;

    //  rst ir ia     dr we da     dwd            ig iv ird           dg dv drd           mq mw ma     mwd           busy
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        0);
    add(1, 1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        0);
    add(1, 1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h20,  32'h0,        1);
    add(1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20,  32'h0,        1);
    add(1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 1, 32'hDEADBEFF, 0, 0, 32'h20,  32'h0,        1);
    add(1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h20,  32'h0,        0);
    add(1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h40,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h40,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBF1F, 0, 0, 32'h0,        0, 0, 32'h40,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h40,  32'h0,        0);
    add(1, 0, 32'h0,  1, 1, 32'h100, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h40,  32'h0,        0);
    add(1, 0, 32'h0,  1, 1, 32'h100, 32'h12345678, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h100, 32'h12345678, 1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h12345678, 1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 1, 32'h0,        0, 0, 32'h100, 32'h12345678, 1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h12345678, 0);
    add(1, 0, 32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h12345678, 0);
    add(1, 0, 32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h100, 32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 1, 32'h12345678, 0, 0, 32'h100, 32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h0,        0);
    add(1, 0, 32'h0,  1, 0, 32'h20,  32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h100, 32'h0,        0);
    add(1, 0, 32'h0,  1, 0, 32'h20,  32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h20,  32'h0,        1);
    add(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    add(1, 0, 32'h40, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        1);
    add(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h10,  32'h0,        0);

    foreach (vt[n]) begin
      drive(vt[n].rst, vt[n].ir, vt[n].ia, vt[n].dr, vt[n].dwe, vt[n].da, vt[n].dwd);
      @(negedge clk);
      act_v = {i_gnt2, i_rvalid2, i_rdata2, d_gnt2, d_rvalid2, d_rdata2,
               m_req2, m_we2, m_addr2, m_wdata2, busy2};
      exp_v = {vt[n].eig, vt[n].eiv, vt[n].eird, vt[n].edg, vt[n].edv, vt[n].edrd,
               vt[n].emq, vt[n].emw, vt[n].ema, vt[n].emwd, vt[n].ebusy};
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL row%0d: got %h expected %h", n, act_v, exp_v);
      end
    end

    // MEM_LAT=1 instance: i read of 0x10, rvalid two cycles after the request
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("lat1 gnt N", {31'b0, i_gnt1}, 32'h0);
    drive(1, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("lat1 gnt N+1", {29'b0, i_gnt1, m_req1, i_rvalid1}, 32'h6);
    chk("lat1 m_addr", m_addr1, 32'h10);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("lat1 rvalid N+2", {30'b0, i_rvalid1, busy1}, 32'h3);
    chk("lat1 rdata", i_rdata1, 32'hDEADBEEF);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("lat1 idle", {30'b0, i_rvalid1, busy1}, 32'h0);

    // Two back-to-back conflicts on the MEM_LAT=2 instance
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 32'h10, 1, 0, 32'h20, 32'h0);
    @(negedge clk); chk("cf1 N no gnt", {30'b0, i_gnt2, d_gnt2}, 32'h0);
    drive(1, 1, 32'h10, 1, 0, 32'h20, 32'h0);
    @(negedge clk); chk("cf1 d wins", {30'b0, i_gnt2, d_gnt2}, 32'h1);
    drive(1, 1, 32'h10, 1, 0, 32'h40, 32'h0);
    @(negedge clk); chk("cf1 busy", {31'b0, busy2}, 32'h1);
    drive(1, 1, 32'h10, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("cf1 d_rvalid", {31'b0, d_rvalid2}, 32'h1);
    chk("cf1 d_rdata", d_rdata2, 32'hDEADBEFF);
    drive(1, 1, 32'h10, 1, 0, 32'h40, 32'h0);
    @(negedge clk); chk("cf2 idle", {31'b0, busy2}, 32'h0);
    drive(1, 1, 32'h10, 1, 0, 32'h40, 32'h0);
    @(negedge clk); chk("cf2 winner", {30'b0, i_gnt2, d_gnt2}, RR ? 32'h2 : 32'h1);

    seen = 1'b0; lat = 0; loser_addr = '0;
    for (int k = 1; k <= 10; k++) begin
      drive(1, !RR, 32'h10, RR, 0, 32'h40, 32'h0);
      @(negedge clk);
      if (RR ? d_gnt2 : i_gnt2) begin
        seen = 1'b1; lat = k; loser_addr = m_addr2;
        break;
      end
    end
    chk("cf2 loser seen", {31'b0, seen}, 32'h1);
    chk("cf2 loser delay", lat, 32'd4);
    chk("cf2 loser addr", loser_addr, RR ? 32'h40 : 32'h10);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
